enemy_scheduler: RTL
====================

ENEMY_SCHEDULER -- requirements
Module: enemy_scheduler

Interface
REQ-001 The block SHALL have parameter N_ENEMY, default 4, meaning number of enemy instances managed (2..8).
REQ-002 The block SHALL have parameter ENEMY_HP, default 3, meaning hits required to kill one enemy.
REQ-003 The block SHALL have parameter COOLDOWN, default 30, meaning frames between two granted player attacks.
REQ-004 The block SHALL have parameter RESPAWN_DELAY, default 120, meaning frames an enemy stays dead before respawn.
REQ-005 game_frame_clk_rising_edge  in  1  clock; Reset  in  1  synchronous, active-high reset.
REQ-006 Game_Active  in  1  high while gameplay runs; low freezes scheduling.
REQ-007 Attack_Ready  in  N_ENEMY  per-enemy attack request (Enemy_Attack_Ready of each enemy).
REQ-008 Enemy_Hit  in  N_ENEMY  per-enemy bullet-hit pulse from the bullet logic.
REQ-009 is_alive  out  N_ENEMY  per-enemy alive flag, drives each enemy's is_alive.
REQ-010 Enemy_Is_Attacked  out  N_ENEMY  one-frame pulse per accepted hit.
REQ-011 Player_Damage  out  1  one-frame pulse when an attack is granted.
REQ-012 Grant_Id  out  $clog2(N_ENEMY)  index of the enemy last granted.
REQ-013 Kill_Count  out  8  total kills, saturating.

Function
REQ-014 Each enemy SHALL have its own FSM with states INACTIVE, ALIVE, DEAD, plus a 3-bit HP counter and a 7-bit respawn timer.
REQ-015 INACTIVE -> ALIVE on the first frame with Game_Active=1; HP loaded to ENEMY_HP.
REQ-016 In ALIVE, Enemy_Hit[i]=1 SHALL decrement HP and assert Enemy_Is_Attacked[i] on the next frame (1-frame latency, registered).
REQ-017 A hit taking HP from 1 to 0 SHALL move ALIVE -> DEAD, clear is_alive[i] next frame, increment Kill_Count (hold at 255), load timer with RESPAWN_DELAY-1, and SHALL NOT assert Enemy_Is_Attacked[i].
REQ-018 In DEAD the timer SHALL count down one per frame; at 0 the enemy SHALL go to ALIVE with HP reloaded and is_alive[i]=1 next frame.
REQ-019 Enemy_Hit[i] SHALL be ignored in INACTIVE and DEAD.
REQ-020 Attack arbiter FSM SHALL have states READY and COOL with a 5-bit cooldown counter.
REQ-021 In READY, eligible[i] = Attack_Ready[i] & ALIVE[i] & ~Enemy_Hit[i]; hit wins over attack in the same frame.
REQ-022 In READY with any eligible, the arbiter SHALL grant round-robin from pointer rr_ptr, pulse Player_Damage for one frame, update Grant_Id, set rr_ptr = (granted+1) mod N_ENEMY, load counter with COOLDOWN-1, go to COOL.
REQ-023 In READY with none eligible, it SHALL stay in READY and change no output.
REQ-024 In COOL, counter SHALL decrement per frame; at 0 it SHALL return to READY; requests during COOL SHALL be dropped, not queued.
REQ-025 Game_Active=0 SHALL force every enemy to INACTIVE (is_alive=0), force arbiter to READY, and suppress Player_Damage and Enemy_Is_Attacked; Kill_Count SHALL hold.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 On Reset: all enemies INACTIVE, HP=ENEMY_HP, timers 0, is_alive=0, Enemy_Is_Attacked=0, Player_Damage=0, Grant_Id=0, rr_ptr=0, Kill_Count=0, arbiter READY.
REQ-028 Reset SHALL override all other inputs in the same frame, including mid-cooldown or mid-respawn.

Structure
REQ-029 The enemy FSM state enum and default constants (ENEMY_HP, COOLDOWN, RESPAWN_DELAY) SHALL live in a shared package game_pkg.
REQ-030 The per-enemy FSM SHALL be a sub-module enemy_life, instantiated N_ENEMY times by a generate loop; the arbiter stays in the top module.

Verification
REQ-031 Reset, Game_Active=1 -> next frame is_alive=4'b1111, Kill_Count=0.
REQ-032 Attack_Ready=4'b1010 held -> grants id 1, then id 3 exactly 30 frames later, then id 1; Player_Damage one frame each.
REQ-033 Three Enemy_Hit[2] pulses on separate frames -> two Enemy_Is_Attacked[2] pulses, then is_alive[2]=0, Kill_Count=1; is_alive[2]=1 again 120 frames later.
REQ-034 Attack_Ready[0]=1 and Enemy_Hit[0]=1 same frame, others idle -> no Player_Damage, Enemy_Is_Attacked[0] pulses.
REQ-035 Reset asserted during COOL at counter 10 -> arbiter READY, Grant_Id=0, next eligible request granted immediately after Game_Active.
REQ-036 256 kills forced -> Kill_Count stays 255.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg
//   Shared types and default constants for the enemy scheduling logic.
//   Provides:
//     enemy_state_t       per-enemy life-cycle state
//     arb_state_t         player-attack arbiter state
//     DEFAULT_*           default gameplay constants used as parameter defaults
//     HP_W/CD_W/RT_W      counter widths (HP, cooldown, respawn timer)
//     KILL_W              width of the saturating kill counter
package game_pkg;

    typedef enum logic [1:0] {
        ST_INACTIVE,
        ST_ALIVE,
        ST_DEAD
    } enemy_state_t;

    typedef enum logic {
        ARB_READY,
        ARB_COOL
    } arb_state_t;

    localparam int unsigned DEFAULT_ENEMY_HP      = 3;
    localparam int unsigned DEFAULT_COOLDOWN      = 30;
    localparam int unsigned DEFAULT_RESPAWN_DELAY = 120;

    localparam int unsigned HP_W   = 3;
    localparam int unsigned CD_W   = 5;
    localparam int unsigned RT_W   = 7;
    localparam int unsigned KILL_W = 8;

endpackage

// File: rtl/enemy_scheduler_if.sv
// enemy_scheduler_if
//   Bundles the gameplay-side signals of enemy_scheduler.
//   master : drives Game_Active, Attack_Ready, Enemy_Hit; observes results
//   slave  : the scheduler; receives requests/hits, drives
//            is_alive, Enemy_Is_Attacked, Player_Damage, Grant_Id, Kill_Count
interface enemy_scheduler_if
    import game_pkg::*;
#(
    parameter int unsigned N_ENEMY = 4
);
    localparam int unsigned ID_W = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;

    logic                Game_Active;
    logic [N_ENEMY-1:0]  Attack_Ready;
    logic [N_ENEMY-1:0]  Enemy_Hit;
    logic [N_ENEMY-1:0]  is_alive;
    logic [N_ENEMY-1:0]  Enemy_Is_Attacked;
    logic                Player_Damage;
    logic [ID_W-1:0]     Grant_Id;
    logic [KILL_W-1:0]   Kill_Count;

    modport master (
        output Game_Active, Attack_Ready, Enemy_Hit,
        input  is_alive, Enemy_Is_Attacked, Player_Damage, Grant_Id, Kill_Count
    );

    modport slave (
        input  Game_Active, Attack_Ready, Enemy_Hit,
        output is_alive, Enemy_Is_Attacked, Player_Damage, Grant_Id, Kill_Count
    );

endinterface

// File: rtl/enemy_life.sv
// enemy_life
//   Life-cycle FSM of one enemy: INACTIVE -> ALIVE -> DEAD -> ALIVE ...
//   Ports:
//     i_clk          frame clock
//     i_reset        synchronous, active-high reset
//     i_game_active  low forces INACTIVE
//     i_hit          bullet-hit pulse for this enemy
//     o_alive        registered alive flag
//     o_attacked     registered one-frame pulse per non-fatal hit
//     o_kill         same-frame strobe of a fatal hit (feeds the registered
//                    kill counter in the parent)
module enemy_life
    import game_pkg::*;
#(
    parameter int unsigned ENEMY_HP      = DEFAULT_ENEMY_HP,
    parameter int unsigned RESPAWN_DELAY = DEFAULT_RESPAWN_DELAY
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_game_active,
    input  logic i_hit,
    output logic o_alive,
    output logic o_attacked,
    output logic o_kill
);

    localparam logic [HP_W-1:0] HP_LOAD = HP_W'(ENEMY_HP);
    localparam logic [RT_W-1:0] RT_LOAD = RT_W'(RESPAWN_DELAY - 1);

    enemy_state_t    r_state, w_state_nxt;
    logic [HP_W-1:0] r_hp, w_hp_nxt;
    logic [RT_W-1:0] r_timer, w_timer_nxt;
    logic            r_alive, w_alive_nxt;
    logic            r_attacked, w_attacked_nxt;
    logic            w_kill;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_INACTIVE;
            r_hp       <= HP_LOAD;
            r_timer    <= '0;
            r_alive    <= 1'b0;
            r_attacked <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hp       <= w_hp_nxt;
            r_timer    <= w_timer_nxt;
            r_alive    <= w_alive_nxt;
            r_attacked <= w_attacked_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hp_nxt       = r_hp;
        w_timer_nxt    = r_timer;
        w_attacked_nxt = 1'b0;
        w_kill         = 1'b0;

        if (!i_game_active) begin
            w_state_nxt = ST_INACTIVE;
        end else begin
            case (r_state)
                ST_INACTIVE: begin
                    w_state_nxt = ST_ALIVE;
                    w_hp_nxt    = HP_LOAD;
                end
                ST_ALIVE: begin
                    if (i_hit) begin
                        if (r_hp <= HP_W'(1)) begin
                            // fatal hit: counted as a kill, not as an attack
                            w_state_nxt = ST_DEAD;
                            w_hp_nxt    = '0;
                            w_timer_nxt = RT_LOAD;
                            w_kill      = 1'b1;
                        end else begin
                            w_hp_nxt       = r_hp - HP_W'(1);
                            w_attacked_nxt = 1'b1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (r_timer == '0) begin
                        w_state_nxt = ST_ALIVE;
                        w_hp_nxt    = HP_LOAD;
                    end else begin
                        w_timer_nxt = r_timer - RT_W'(1);
                    end
                end
                default: w_state_nxt = ST_INACTIVE;
            endcase
        end

        w_alive_nxt = (w_state_nxt == ST_ALIVE);
    end

    assign o_alive    = r_alive;
    assign o_attacked = r_attacked;
    assign o_kill     = w_kill;

endmodule

// File: rtl/enemy_scheduler.sv
// enemy_scheduler
//   Manages N_ENEMY enemy life cycles and a round-robin player-attack arbiter
//   with a cooldown between granted attacks. All outputs are registered.
//   Ports:
//     game_frame_clk_rising_edge  frame clock
//     Reset                       synchronous, active-high reset
//     bus (slave)                 Game_Active, Attack_Ready, Enemy_Hit in;
//                                 is_alive, Enemy_Is_Attacked, Player_Damage,
//                                 Grant_Id, Kill_Count out
module enemy_scheduler
    import game_pkg::*;
#(
    parameter int unsigned N_ENEMY       = 4,
    parameter int unsigned ENEMY_HP      = DEFAULT_ENEMY_HP,
    parameter int unsigned COOLDOWN      = DEFAULT_COOLDOWN,
    parameter int unsigned RESPAWN_DELAY = DEFAULT_RESPAWN_DELAY
) (
    input  logic               game_frame_clk_rising_edge,
    input  logic               Reset,
    enemy_scheduler_if.slave   bus
);

    localparam int unsigned     ID_W    = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN - 1);

    logic [N_ENEMY-1:0] w_alive;
    logic [N_ENEMY-1:0] w_attacked;
    logic [N_ENEMY-1:0] w_kill;

    for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_enemy
        enemy_life #(
            .ENEMY_HP      (ENEMY_HP),
            .RESPAWN_DELAY (RESPAWN_DELAY)
        ) u_life (
            .i_clk         (game_frame_clk_rising_edge),
            .i_reset       (Reset),
            .i_game_active (bus.Game_Active),
            .i_hit         (bus.Enemy_Hit[gi]),
            .o_alive       (w_alive[gi]),
            .o_attacked    (w_attacked[gi]),
            .o_kill        (w_kill[gi])
        );
    end

    // ---------------- kill counter (saturating) ----------------
    logic [KILL_W-1:0] r_kill_count, w_kill_count_nxt;
    logic [KILL_W:0]   w_kill_sum;

    always_comb begin
        w_kill_sum = {1'b0, r_kill_count};
        for (int unsigned i = 0; i < N_ENEMY; i++) begin
            w_kill_sum = w_kill_sum + (KILL_W+1)'(w_kill[i]);
        end
        w_kill_count_nxt = w_kill_sum[KILL_W] ? '1 : w_kill_sum[KILL_W-1:0];
    end

    // ---------------- round-robin pick ----------------
    logic [ID_W-1:0]    r_rr_ptr, w_rr_nxt;
    logic [N_ENEMY-1:0] w_eligible;
    logic               w_found;
    logic [ID_W-1:0]    w_pick;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_idx;

    always_comb begin
        // a hit in the same frame beats the attack request
        w_eligible = bus.Attack_Ready & w_alive & ~bus.Enemy_Hit;
        w_found    = 1'b0;
        w_pick     = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int unsigned k = 0; k < N_ENEMY; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N_ENEMY)) begin
                w_sum = w_sum - (ID_W+1)'(N_ENEMY);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // ---------------- attack arbiter ----------------
    arb_state_t      r_arb_state, w_arb_state_nxt;
    logic [CD_W-1:0] r_cd, w_cd_nxt;
    logic [ID_W-1:0] r_grant_id, w_grant_id_nxt;
    logic            r_damage, w_damage_nxt;

    always_ff @(posedge game_frame_clk_rising_edge) begin
        if (Reset) begin
            r_arb_state  <= ARB_READY;
            r_cd         <= '0;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_damage     <= 1'b0;
            r_kill_count <= '0;
        end else begin
            r_arb_state  <= w_arb_state_nxt;
            r_cd         <= w_cd_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_damage     <= w_damage_nxt;
            r_kill_count <= w_kill_count_nxt;
        end
    end

    always_comb begin
        w_arb_state_nxt = r_arb_state;
        w_cd_nxt        = r_cd;
        w_rr_nxt        = r_rr_ptr;
        w_grant_id_nxt  = r_grant_id;
        w_damage_nxt    = 1'b0;

        if (!bus.Game_Active) begin
            w_arb_state_nxt = ARB_READY;
            w_cd_nxt        = '0;
        end else begin
            case (r_arb_state)
                ARB_READY: begin
                    if (w_found) begin
                        w_damage_nxt    = 1'b1;
                        w_grant_id_nxt  = w_pick;
                        w_rr_nxt        = (w_pick == ID_W'(N_ENEMY - 1)) ? '0 : w_pick + ID_W'(1);
                        w_cd_nxt        = CD_LOAD;
                        w_arb_state_nxt = (COOLDOWN > 1) ? ARB_COOL : ARB_READY;
                    end
                end
                ARB_COOL: begin
                    // Leave COOL on the frame the counter reaches 0 so that
                    // consecutive grants are exactly COOLDOWN frames apart.
                    if (r_cd <= CD_W'(1)) begin
                        w_cd_nxt        = '0;
                        w_arb_state_nxt = ARB_READY;
                    end else begin
                        w_cd_nxt = r_cd - CD_W'(1);
                    end
                end
                default: w_arb_state_nxt = ARB_READY;
            endcase
        end
    end

    assign bus.is_alive          = w_alive;
    assign bus.Enemy_Is_Attacked = w_attacked;
    assign bus.Player_Damage     = r_damage;
    assign bus.Grant_Id          = r_grant_id;
    assign bus.Kill_Count        = r_kill_count;

endmodule
